// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding and bit-count constants.
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } i2c_state_e;
  localparam logic [3:0] BYTE_BITS = 4'd8;
  // Marks the first read byte of a transfer: its MSB is driven as soon as the data is loaded.
  localparam logic [3:0] FIRST_RD  = 4'd9;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA and detects SCL edges plus START/STOP.
//   clk, reset          : system clock, synchronous active-high reset
//   scl_i, sda_i        : raw asynchronous pin levels
//   sda_o               : synchronized SDA level
//   scl_rise_o/fall_o   : one-clk pulses on synchronized SCL edges
//   start_o/stop_o      : one-clk pulses on START / STOP conditions
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  // [1:0] is the 2-FF synchronizer, [2] the delay stage used for edge detection.
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end
  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with an 8-bit register pointer and auto-increment.
//   clk, reset            : system clock, synchronous active-high reset
//   scl_in, sda_in        : raw bus levels; sda_oe pulls SDA low
//   reg_addr/wdata/we     : register write port, reg_we pulses per data byte
//   reg_rdata/reg_re      : register read port, data sampled the clk after reg_re
//   busy, nack_rx         : addressed-transfer flag, master-NACK pulse
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       reg_re,
  output logic       busy,
  output logic       nack_rx
);
  logic sda, rise, fall, start, stop;
  i2c_bus_sync u_sync (
    .clk(clk), .reset(reset), .scl_i(scl_in), .sda_i(sda_in), .sda_o(sda),
    .scl_rise_o(rise), .scl_fall_o(fall), .start_o(start), .stop_o(stop)
  );
  i2c_state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] sh_q, reg_addr_q, reg_wdata_q;
  logic       rw_q, sda_oe_q, reg_we_q, reg_re_q, busy_q, nack_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= BYTE_BITS;
      sh_q        <= 8'h00;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      nack_q   <= 1'b0;
      if (stop) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start) begin
        state_q  <= ADDR;
        cnt_q    <= BYTE_BITS;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (rise) begin
              sh_q  <= {sh_q[6:0], sda};
              cnt_q <= cnt_q - 4'd1;
            end else if (fall && cnt_q == 4'd0) begin
              if (state_q == ADDR) begin
                if (sh_q[7:1] == DEV_ADDR) begin
                  state_q  <= ADDR_ACK;
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  rw_q     <= sh_q[0];
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end else begin
                sda_oe_q <= 1'b1;
                if (state_q == PTR) begin
                  reg_addr_q <= sh_q;
                  state_q    <= PTR_ACK;
                end else begin
                  reg_wdata_q <= sh_q;
                  reg_we_q    <= 1'b1;
                  state_q     <= WDATA_ACK;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (fall) begin
              if (rw_q) begin
                reg_re_q <= 1'b1;
                cnt_q    <= FIRST_RD;
                state_q  <= RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                cnt_q    <= BYTE_BITS;
                state_q  <= PTR;
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (fall) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= BYTE_BITS;
              state_q  <= WDATA;
              if (state_q == WDATA_ACK) reg_addr_q <= reg_addr_q + 8'd1;
            end
          end
          RDATA: begin
            // The first byte's MSB replaces the address ACK directly; later bytes wait for SCL fall.
            if (reg_re_q) begin
              sh_q <= cnt_q == FIRST_RD ? {reg_rdata[6:0], 1'b0} : reg_rdata;
              if (cnt_q == FIRST_RD) begin
                sda_oe_q <= ~reg_rdata[7];
                cnt_q    <= 4'd7;
              end
            end else if (fall) begin
              if (cnt_q == 4'd0) begin
                sda_oe_q <= 1'b0;
                state_q  <= RDATA_ACK;
              end else begin
                sda_oe_q <= ~sh_q[7];
                sh_q     <= {sh_q[6:0], 1'b0};
                cnt_q    <= cnt_q - 4'd1;
              end
            end
          end
          RDATA_ACK: begin
            if (rise) begin
              if (!sda) begin
                reg_addr_q <= reg_addr_q + 8'd1;
                reg_re_q   <= 1'b1;
                cnt_q      <= BYTE_BITS;
                state_q    <= RDATA;
              end else begin
                nack_q  <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign nack_rx   = nack_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-level bench for i2c_slave with write/read scoreboards.
module tb_i2c_slave;
  logic clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, reg_we, reg_re, busy, nack_rx, sda_line;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [7:0] regs [256];
  logic [15:0] wq [$];
  logic [7:0] rq [$];
  logic [15:0] we_exp;
  int passed = 0, total = 0, fails = 0, re_cnt = 0, nack_cnt = 0, oe_cnt = 0;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = regs[reg_addr];
  always #5 clk = ~clk;

  i2c_slave #(.DEV_ADDR(7'h50)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata),
    .reg_re(reg_re), .busy(busy), .nack_rx(nack_rx)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic q(); repeat (8) @(negedge clk); endtask
  task automatic start_c(); sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q(); endtask
  task automatic stop_c(); sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q(); endtask
  task automatic bit_c(input logic b, output logic r);
    sda_m = b; q(); scl_m = 1'b1; q(); r = sda_line; q(); scl_m = 1'b0; q();
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_c(d[i], r);
    bit_c(1'b1, ack);
  endtask
  task automatic wr_ack(input string tag, input logic [7:0] d);
    logic a;
    wr_byte(d, a);
    check(tag, {15'h0, a}, 16'h0);
  endtask
  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin bit_c(1'b1, r); d[i] = r; end
    bit_c(mack, r);
  endtask

  always @(negedge clk) if (!reset) begin
    if (reg_we) begin
      if (wq.size() == 0) check("we_unexpected", {15'h0, reg_we}, 16'h0);
      else begin
        we_exp = wq.pop_front();
        check("we_addr", {8'h0, reg_addr}, {8'h0, we_exp[15:8]});
        check("we_data", {8'h0, reg_wdata}, {8'h0, we_exp[7:0]});
      end
    end
    if (reg_re) re_cnt++;
    if (nack_rx) nack_cnt++;
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic a;
    logic [7:0] d;
    int re0, waited;
    for (int i = 0; i < 256; i++) regs[i] = 8'(i ^ 8'hA5);
    repeat (3) @(negedge clk);
    check("rst_sda_oe", {15'h0, sda_oe}, 16'h0);
    check("rst_reg_addr", {8'h0, reg_addr}, 16'h0);
    check("rst_reg_wdata", {8'h0, reg_wdata}, 16'h0);
    check("rst_we_re", {14'h0, reg_we, reg_re}, 16'h0);
    check("rst_busy_nack", {14'h0, busy, nack_rx}, 16'h0);
    reset = 1'b0;
    q();
    // write two bytes from pointer 0x10
    wq.push_back(16'h105A); wq.push_back(16'h11C3);
    start_c();
    wr_ack("wr_addr_ack", 8'hA0);
    check("wr_busy", {15'h0, busy}, 16'h1);
    wr_ack("wr_ptr_ack", 8'h10);
    wr_ack("wr_d0_ack", 8'h5A);
    wr_ack("wr_d1_ack", 8'hC3);
    stop_c();
    check("wr_busy_after_stop", {15'h0, busy}, 16'h0);
    check("wr_queue_empty", 16'(wq.size()), 16'h0);
    check("wr_ptr_final", {8'h0, reg_addr}, 16'h0012);
    // read two bytes from 0x20 via repeated start
    regs[8'h20] = 8'h3C; regs[8'h21] = 8'h81;
    re0 = re_cnt; nack_cnt = 0;
    rq.push_back(8'h3C); rq.push_back(8'h81);
    start_c();
    wr_ack("rd_addr_ack", 8'hA0);
    wr_ack("rd_ptr_ack", 8'h20);
    start_c();
    wr_ack("rd_addr1_ack", 8'hA1);
    rd_byte(1'b0, d);
    check("rd_byte0", {8'h0, d}, {8'h0, rq.pop_front()});
    rd_byte(1'b1, d);
    check("rd_byte1", {8'h0, d}, {8'h0, rq.pop_front()});
    check("rd_nack_pulses", 16'(nack_cnt), 16'h1);
    check("rd_sda_released", {15'h0, sda_oe}, 16'h0);
    check("rd_re_pulses", 16'(re_cnt - re0), 16'h2);
    stop_c();
    // address mismatch
    oe_cnt = 0; re0 = re_cnt;
    start_c();
    wr_byte(8'hA2, a);
    check("mm_addr_nack", {15'h0, a}, 16'h1);
    wr_byte(8'h10, a);
    check("mm_data_nack", {15'h0, a}, 16'h1);
    stop_c();
    check("mm_no_drive", 16'(oe_cnt), 16'h0);
    check("mm_no_re", 16'(re_cnt - re0), 16'h0);
    check("mm_busy", {15'h0, busy}, 16'h0);
    // pointer wrap
    wq.push_back(16'hFF11); wq.push_back(16'h0022);
    start_c();
    wr_ack("wrap_addr_ack", 8'hA0);
    wr_ack("wrap_ptr_ack", 8'hFF);
    wr_ack("wrap_d0_ack", 8'h11);
    wr_ack("wrap_d1_ack", 8'h22);
    stop_c();
    check("wrap_queue_empty", 16'(wq.size()), 16'h0);
    check("wrap_ptr_final", {8'h0, reg_addr}, 16'h0001);
    // STOP after four data bits, then a valid write
    start_c();
    wr_ack("part_addr_ack", 8'hA0);
    wr_ack("part_ptr_ack", 8'h30);
    for (int i = 0; i < 4; i++) bit_c(1'(i & 1), a);
    stop_c();
    check("part_busy", {15'h0, busy}, 16'h0);
    check("part_ptr", {8'h0, reg_addr}, 16'h0030);
    wq.push_back(16'h4077);
    start_c();
    wr_ack("post_part_addr_ack", 8'hA0);
    wr_ack("post_part_ptr_ack", 8'h40);
    wr_ack("post_part_d_ack", 8'h77);
    stop_c();
    check("post_part_queue_empty", 16'(wq.size()), 16'h0);
    // reset while the slave drives a 0 read bit
    regs[8'h50] = 8'h00;
    start_c();
    wr_ack("rst_rd_addr_ack", 8'hA0);
    wr_ack("rst_rd_ptr_ack", 8'h50);
    start_c();
    wr_ack("rst_rd_addr1_ack", 8'hA1);
    waited = 0;
    while (!sda_oe && waited < 200) begin @(negedge clk); waited++; end
    check("rst_rd_driving", {15'h0, sda_oe}, 16'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_rd_release", {15'h0, sda_oe}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    q();
    start_c();
    wr_ack("post_rst_addr_ack", 8'hA0);
    stop_c();
    check("final_queue_empty", 16'(wq.size() + rq.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
